// File: rtl/trap_csr_unit.sv
// rtl/trap_csr_unit.sv - machine-mode trap responder and M-mode CSR file
//
// Purpose:
//   Accepts ID-stage trap/MRET requests. On an accepted request it issues a
//   one-cycle redirect pulse with the handler or return target. It owns the
//   mstatus, mtvec, mepc, mcause and mscratch CSRs, and it serves
//   CSRRW/CSRRS/CSRRC accesses from the EX stage.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   trap_valid, int_cause,     ID trap request: the cause
//   mret, trap_pc              (00 none, 01 illegal, 10 ecall, 11 external),
//                              the MRET flag and the instruction PC
//   csr_en, csr_op, csr_addr,  EX CSR access (01 RW, 10 RS, 11 RC)
//   csr_wdata
//   csr_rdata, csr_illegal     old CSR value (combinational), bad-address flag
//   redirect, redirect_pc      one-cycle PC redirect + IF/ID flush, and its target
//   int_enable                 mstatus.MIE
//
// Configuration macro: TRAP_VECTORED_EN (vectored mtvec mode for external interrupts)

module trap_csr_unit #(
    parameter int unsigned         XLEN        = 32,
    parameter logic [XLEN-1:0]     RESET_MTVEC = 32'h0000_0100,
    parameter int unsigned         EPC_ALIGN   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            trap_valid,
    input  logic [1:0]      int_cause,
    input  logic            mret,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            csr_en,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            int_enable
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;

    localparam logic [XLEN-1:0] EPC_MASK = ~((XLEN'(1) << EPC_ALIGN) - XLEN'(1));

    typedef enum logic {S_IDLE, S_REDIR} state_t;

    state_t          r_state;
    logic            r_mie;
    logic            r_mpie;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mscratch;
    logic            r_redirect;
    logic [XLEN-1:0] r_redirect_pc;

    logic [XLEN-1:0] w_mstatus;
    logic [XLEN-1:0] w_old;
    logic            w_legal;
    logic [XLEN-1:0] w_new;
    logic            w_csr_we;
    logic [XLEN-1:0] w_mtvec_wval;
    logic            w_is_exc;
    logic            w_is_ext;
    logic            w_take_trap;
    logic            w_take_mret;
    logic [XLEN-1:0] w_cause_val;
    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_trap_target;

    // CSR read mux: always the pre-edge value
    always_comb begin
        w_mstatus    = '0;
        w_mstatus[3] = r_mie;
        w_mstatus[7] = r_mpie;
        w_old        = '0;
        w_legal      = 1'b1;
        case (csr_addr)
            ADDR_MSTATUS:  w_old = w_mstatus;
            ADDR_MTVEC:    w_old = r_mtvec;
            ADDR_MSCRATCH: w_old = r_mscratch;
            ADDR_MEPC:     w_old = r_mepc;
            ADDR_MCAUSE:   w_old = r_mcause;
            default:       w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_new = w_old;
        case (csr_op)
            2'b01:   w_new = csr_wdata;
            2'b10:   w_new = w_old | csr_wdata;
            2'b11:   w_new = w_old & ~csr_wdata;
            default: w_new = w_old;
        endcase
    end

    assign w_csr_we    = csr_en && (csr_op != 2'b00) && w_legal;
    assign csr_rdata   = w_old;
    assign csr_illegal = csr_en && !w_legal;

`ifdef TRAP_VECTORED_EN
    // Only mode 00 (direct) and 01 (vectored) are representable; 1x collapses to direct
    assign w_mtvec_wval = {w_new[XLEN-1:2], (w_new[1:0] == 2'b01) ? 2'b01 : 2'b00};
`else
    assign w_mtvec_wval = {w_new[XLEN-1:2], 2'b00};
`endif

    // Trap/MRET acceptance; an external interrupt with MIE clear counts as no cause
    assign w_is_exc    = (int_cause == 2'b01) || (int_cause == 2'b10);
    assign w_is_ext    = (int_cause == 2'b11) && r_mie;
    assign w_take_trap = (r_state == S_IDLE) && trap_valid && (w_is_exc || w_is_ext);
    assign w_take_mret = (r_state == S_IDLE) && trap_valid && mret && !w_take_trap;

    always_comb begin
        w_cause_val = '0;
        case (int_cause)
            2'b01:   w_cause_val[3:0] = 4'd2;
            2'b10:   w_cause_val[3:0] = 4'd11;
            2'b11: begin
                w_cause_val[XLEN-1] = 1'b1;
                w_cause_val[3:0]    = 4'd11;
            end
            default: w_cause_val = '0;
        endcase
    end

    assign w_base = {r_mtvec[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    assign w_trap_target = ((r_mtvec[1:0] == 2'b01) && (int_cause == 2'b11))
                         ? (w_base + XLEN'(32'h2C)) : w_base;
`else
    assign w_trap_target = w_base;
`endif

    // Trap/MRET updates are ordered after the CSR write so they win for
    // mstatus, mepc and mcause when both land on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_mie         <= 1'b0;
            r_mpie        <= 1'b0;
            r_mtvec       <= {RESET_MTVEC[XLEN-1:2], 2'b00}
`ifdef TRAP_VECTORED_EN
                           | {{(XLEN-2){1'b0}}, (RESET_MTVEC[1:0] == 2'b01) ? 2'b01 : 2'b00}
`endif
                           ;
            r_mepc        <= '0;
            r_mcause      <= '0;
            r_mscratch    <= '0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            if (w_csr_we) begin
                case (csr_addr)
                    ADDR_MSTATUS: begin
                        r_mie  <= w_new[3];
                        r_mpie <= w_new[7];
                    end
                    ADDR_MTVEC:    r_mtvec    <= w_mtvec_wval;
                    ADDR_MSCRATCH: r_mscratch <= w_new;
                    ADDR_MEPC:     r_mepc     <= w_new & EPC_MASK;
                    ADDR_MCAUSE:   r_mcause   <= w_new;
                    default:       ;
                endcase
            end

            case (r_state)
                S_IDLE: begin
                    r_redirect <= 1'b0;
                    if (w_take_trap) begin
                        r_mepc        <= trap_pc & EPC_MASK;
                        r_mcause      <= w_cause_val;
                        r_mpie        <= r_mie;
                        r_mie         <= 1'b0;
                        r_redirect    <= 1'b1;
                        r_redirect_pc <= w_trap_target;
                        r_state       <= S_REDIR;
                    end else if (w_take_mret) begin
                        r_mie         <= r_mpie;
                        r_mpie        <= 1'b1;
                        r_redirect    <= 1'b1;
                        r_redirect_pc <= r_mepc;
                        r_state       <= S_REDIR;
                    end
                end
                S_REDIR: begin
                    r_redirect <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_redirect <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign redirect    = r_redirect;
    assign redirect_pc = r_redirect_pc;
    assign int_enable  = r_mie;

endmodule

// File: tb/tb_trap_csr_unit.sv
// tb/tb_trap_csr_unit.sv - directed self-checking bench for trap_csr_unit

module tb_trap_csr_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trap_valid;
    logic [1:0]  int_cause;
    logic        mret;
    logic [31:0] trap_pc;
    logic        csr_en;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        int_enable;

    int total = 0;
    int bad   = 0;

    trap_csr_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .trap_valid  (trap_valid),
        .int_cause   (int_cause),
        .mret        (mret),
        .trap_pc     (trap_pc),
        .csr_en      (csr_en),
        .csr_op      (csr_op),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .csr_illegal (csr_illegal),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .int_enable  (int_enable)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        trap_valid = 1'b0;
        int_cause  = 2'b00;
        mret       = 1'b0;
        trap_pc    = 32'h0;
        csr_en     = 1'b0;
        csr_op     = 2'b00;
        csr_addr   = 12'h0;
        csr_wdata  = 32'h0;
    endtask

    task automatic csr_read(input logic [11:0] addr, output logic [31:0] val, output logic ill);
        csr_en   = 1'b1;
        csr_op   = 2'b00;
        csr_addr = addr;
        #1;
        val = csr_rdata;
        ill = csr_illegal;
        csr_en = 1'b0;
    endtask

    task automatic csr_write(input logic [1:0] op, input logic [11:0] addr,
                             input logic [31:0] data, output logic [31:0] old);
        csr_en    = 1'b1;
        csr_op    = op;
        csr_addr  = addr;
        csr_wdata = data;
        #1;
        old = csr_rdata;
        tick();
        clear_inputs();
    endtask

    // Drives a request for the accepting edge; the bench is then sitting in the REDIR cycle
    task automatic request(input logic [1:0] cause, input logic is_mret, input logic [31:0] pc);
        trap_valid = 1'b1;
        int_cause  = cause;
        mret       = is_mret;
        trap_pc    = pc;
        tick();
        clear_inputs();
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic        ill;
        csr_read(12'h305, v, ill);
        total++; if (v !== 32'h100) begin bad++; $display("FAIL reset_mtvec got=%h exp=%h", v, 32'h100); end
        csr_read(12'h300, v, ill);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_mstatus got=%h exp=%h", v, 32'h0); end
        total++; if (redirect !== 1'b0) begin bad++; $display("FAIL reset_redirect got=%b exp=0", redirect); end
        total++; if (redirect_pc !== 32'h0) begin bad++; $display("FAIL reset_redirect_pc got=%h exp=0", redirect_pc); end
        total++; if (int_enable !== 1'b0) begin bad++; $display("FAIL reset_mie got=%b exp=0", int_enable); end
    endtask

    task automatic test_csr_ops();
        logic [31:0] v;
        logic        ill;
        csr_write(2'b01, 12'h340, 32'hA5, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL rw_old got=%h exp=0", v); end
        csr_write(2'b10, 12'h340, 32'h0F, v);
        total++; if (v !== 32'hA5) begin bad++; $display("FAIL rs_old got=%h exp=a5", v); end
        csr_read(12'h340, v, ill);
        total++; if (v !== 32'hAF) begin bad++; $display("FAIL rs_result got=%h exp=af", v); end
        csr_write(2'b11, 12'h340, 32'hA0, v);
        csr_read(12'h340, v, ill);
        total++; if (v !== 32'h0F) begin bad++; $display("FAIL rc_result got=%h exp=0f", v); end
        csr_read(12'h7C0, v, ill);
        total++; if (ill !== 1'b1 || v !== 32'h0) begin bad++; $display("FAIL illegal_addr got ill=%b data=%h exp ill=1 data=0", ill, v); end
        csr_read(12'h342, v, ill);
        total++; if (ill !== 1'b0) begin bad++; $display("FAIL legal_addr got ill=%b exp=0", ill); end
        // mstatus: only MIE/MPIE stick
        csr_write(2'b01, 12'h300, 32'hFFFF_FF77, v);
        csr_read(12'h300, v, ill);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL mstatus_mask got=%h exp=0", v); end
        // Mode bits 11 collapse to 00 in either build
        csr_write(2'b01, 12'h305, 32'h303, v);
        csr_read(12'h305, v, ill);
        total++; if (v !== 32'h300) begin bad++; $display("FAIL mtvec_low_bits got=%h exp=300", v); end
        csr_write(2'b01, 12'h305, 32'h100, v);
        csr_write(2'b01, 12'h341, 32'h47, v);
        csr_read(12'h341, v, ill);
        total++; if (v !== 32'h44) begin bad++; $display("FAIL mepc_align got=%h exp=44", v); end
    endtask

    task automatic test_ecall();
        logic [31:0] v;
        logic        ill;
        request(2'b10, 1'b0, 32'h40);
        total++; if (redirect !== 1'b1 || redirect_pc !== 32'h100) begin bad++; $display("FAIL ecall_redirect got r=%b pc=%h exp r=1 pc=100", redirect, redirect_pc); end
        tick();
        total++; if (redirect !== 1'b0) begin bad++; $display("FAIL ecall_pulse_width got=%b exp=0", redirect); end
        csr_read(12'h341, v, ill);
        total++; if (v !== 32'h40) begin bad++; $display("FAIL ecall_mepc got=%h exp=40", v); end
        csr_read(12'h342, v, ill);
        total++; if (v !== 32'd11) begin bad++; $display("FAIL ecall_mcause got=%h exp=b", v); end
        total++; if (int_enable !== 1'b0) begin bad++; $display("FAIL ecall_mie got=%b exp=0", int_enable); end
    endtask

    task automatic test_ext_masked();
        logic [31:0] v;
        logic        ill;
        request(2'b11, 1'b0, 32'h84);
        total++; if (redirect !== 1'b0) begin bad++; $display("FAIL ext_masked_redirect got=%b exp=0", redirect); end
        csr_read(12'h341, v, ill);
        total++; if (v !== 32'h40) begin bad++; $display("FAIL ext_masked_mepc got=%h exp=40", v); end
        csr_read(12'h342, v, ill);
        total++; if (v !== 32'd11) begin bad++; $display("FAIL ext_masked_mcause got=%h exp=b", v); end
    endtask

    task automatic test_ext_and_back_to_back();
        logic [31:0] v;
        logic        ill;
        csr_write(2'b10, 12'h300, 32'h8, v);
        total++; if (int_enable !== 1'b1) begin bad++; $display("FAIL set_mie got=%b exp=1", int_enable); end
        request(2'b11, 1'b0, 32'h84);
        total++; if (redirect !== 1'b1 || redirect_pc !== 32'h100) begin bad++; $display("FAIL ext_redirect got r=%b pc=%h exp r=1 pc=100", redirect, redirect_pc); end
        // Second request arrives during REDIR and must be dropped
        request(2'b10, 1'b0, 32'h90);
        total++; if (redirect !== 1'b0) begin bad++; $display("FAIL b2b_redirect got=%b exp=0", redirect); end
        tick();
        total++; if (redirect !== 1'b0) begin bad++; $display("FAIL b2b_late_redirect got=%b exp=0", redirect); end
        csr_read(12'h342, v, ill);
        total++; if (v !== 32'h8000_000B) begin bad++; $display("FAIL ext_mcause got=%h exp=8000000b", v); end
        csr_read(12'h341, v, ill);
        total++; if (v !== 32'h84) begin bad++; $display("FAIL ext_mepc got=%h exp=84", v); end
        csr_read(12'h300, v, ill);
        total++; if (v !== 32'h80) begin bad++; $display("FAIL ext_mstatus got=%h exp=80", v); end
    endtask

    task automatic test_mret();
        logic [31:0] v;
        logic        ill;
        request(2'b00, 1'b1, 32'h200);
        total++; if (redirect !== 1'b1 || redirect_pc !== 32'h84) begin bad++; $display("FAIL mret_redirect got r=%b pc=%h exp r=1 pc=84", redirect, redirect_pc); end
        tick();
        csr_read(12'h300, v, ill);
        total++; if (v !== 32'h88) begin bad++; $display("FAIL mret_mstatus got=%h exp=88", v); end
        // MRET together with an exception: the exception is taken
        request(2'b01, 1'b1, 32'h53);
        total++; if (redirect !== 1'b1 || redirect_pc !== 32'h100) begin bad++; $display("FAIL prio_redirect got r=%b pc=%h exp r=1 pc=100", redirect, redirect_pc); end
        tick();
        csr_read(12'h341, v, ill);
        total++; if (v !== 32'h50) begin bad++; $display("FAIL prio_mepc got=%h exp=50", v); end
        csr_read(12'h342, v, ill);
        total++; if (v !== 32'd2) begin bad++; $display("FAIL prio_mcause got=%h exp=2", v); end
        csr_read(12'h300, v, ill);
        total++; if (v !== 32'h80) begin bad++; $display("FAIL prio_mstatus got=%h exp=80", v); end
    endtask

    task automatic test_same_edge();
        logic [31:0] v;
        logic        ill;
        // CSR write of mtvec lands together with an ecall: both take effect
        trap_valid = 1'b1; int_cause = 2'b10; trap_pc = 32'h60;
        csr_en = 1'b1; csr_op = 2'b01; csr_addr = 12'h305; csr_wdata = 32'h300;
        #1;
        total++; if (csr_rdata !== 32'h100) begin bad++; $display("FAIL same_edge_old_read got=%h exp=100", csr_rdata); end
        tick();
        clear_inputs();
        total++; if (redirect_pc !== 32'h100) begin bad++; $display("FAIL same_edge_target got=%h exp=100", redirect_pc); end
        tick();
        csr_read(12'h305, v, ill);
        total++; if (v !== 32'h300) begin bad++; $display("FAIL same_edge_mtvec got=%h exp=300", v); end
        // CSR write of mepc collides with a trap: trap value wins
        trap_valid = 1'b1; int_cause = 2'b10; trap_pc = 32'h70;
        csr_en = 1'b1; csr_op = 2'b01; csr_addr = 12'h341; csr_wdata = 32'h1234;
        tick();
        clear_inputs();
        total++; if (redirect_pc !== 32'h300) begin bad++; $display("FAIL same_edge_target2 got=%h exp=300", redirect_pc); end
        tick();
        csr_read(12'h341, v, ill);
        total++; if (v !== 32'h70) begin bad++; $display("FAIL same_edge_mepc got=%h exp=70", v); end
    endtask

`ifdef TRAP_VECTORED_EN
    task automatic test_vectored();
        logic [31:0] v;
        csr_write(2'b01, 12'h305, 32'h201, v);
        csr_write(2'b10, 12'h300, 32'h8, v);
        request(2'b11, 1'b0, 32'hA0);
        total++; if (redirect !== 1'b1 || redirect_pc !== 32'h22C) begin bad++; $display("FAIL vec_ext got r=%b pc=%h exp r=1 pc=22c", redirect, redirect_pc); end
        tick();
        request(2'b01, 1'b0, 32'hB0);
        total++; if (redirect !== 1'b1 || redirect_pc !== 32'h200) begin bad++; $display("FAIL vec_exc got r=%b pc=%h exp r=1 pc=200", redirect, redirect_pc); end
        tick();
    endtask
`endif

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        test_reset();
        test_csr_ops();
        test_ecall();
        test_ext_masked();
        test_ext_and_back_to_back();
        test_mret();
        test_same_edge();
`ifdef TRAP_VECTORED_EN
        test_vectored();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
